// File: rtl/spi_target_pkg.sv
// Shared types and SPI mode constants for the spi_target block.
package spi_target_pkg;

    typedef enum logic {
        IDLE   = 1'b0,
        ACTIVE = 1'b1
    } state_t;

    localparam logic SPI_CPOL = 1'b0;
    localparam logic SPI_CPHA = 1'b0;

endpackage

// File: rtl/spi_target_sync.sv
// Multi-flop synchroniser followed by registered rise/fall detection.
module spi_target_sync #(
    parameter int STAGES = 2
) (
    input  logic clk,
    input  logic rst_n,
    input  logic din,
    output logic rise,
    output logic fall
);

    logic [STAGES-1:0] chain;
    logic              prev;
    logic              level;

    assign level = chain[STAGES-1];

    // Edge pulses are registered so downstream logic sees clean one-cycle strobes.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            chain <= '0;
            prev  <= 1'b0;
            rise  <= 1'b0;
            fall  <= 1'b0;
        end else begin
            chain <= (chain << 1) | STAGES'(din);
            prev  <= level;
            rise  <= level & ~prev;
            fall  <= ~level & prev;
        end
    end

endmodule

// File: rtl/spi_target.sv
// SPI mode-0 target: synchronised pins, MSB-first word shifter and
// valid/ready handshakes for transmit and receive words.
module spi_target
    import spi_target_pkg::*;
#(
    parameter int DW          = 8,
    parameter int SYNC_STAGES = 2
) (
    input  logic          clk_i,
    input  logic          rst_ni,
    input  logic          sclk_i,
    input  logic          ss_ni,
    input  logic          sd_i,
    output logic          sd_o,
    output logic          sd_oe,
    input  logic [DW-1:0] tx_data_i,
    input  logic          tx_valid_i,
    output logic          tx_ready_o,
    output logic [DW-1:0] rx_data_o,
    output logic          rx_valid_o,
    input  logic          rx_ready_i,
    output logic          overrun_o,
    output logic          underrun_o
);

    localparam int            CW       = (DW > 1) ? $clog2(DW) : 1;
    localparam logic [CW-1:0] LAST_BIT = CW'(DW - 1);

    state_t                 state;
    logic [DW-1:0]          tx_hold;
    logic [DW-1:0]          tx_shift;
    logic [DW-1:0]          rx_shift;
    logic                   hold_full;
    logic                   word_end;
    logic                   word_done;
    logic [CW-1:0]          bit_cnt;
    logic [SYNC_STAGES-1:0] sd_sync;
    logic                   sd_bit;
    logic                   sclk_rise;
    logic                   sclk_fall;
    logic                   ss_rise;
    logic                   ss_fall;
    logic                   sample_edge;
    logic                   shift_edge;

    spi_target_sync #(.STAGES(SYNC_STAGES)) u_sclk_sync (
        .clk   (clk_i),
        .rst_n (rst_ni),
        .din   (sclk_i),
        .rise  (sclk_rise),
        .fall  (sclk_fall)
    );

    spi_target_sync #(.STAGES(SYNC_STAGES)) u_ss_sync (
        .clk   (clk_i),
        .rst_n (rst_ni),
        .din   (ss_ni),
        .rise  (ss_rise),
        .fall  (ss_fall)
    );

    always_ff @(posedge clk_i or negedge rst_ni) begin
        if (!rst_ni) sd_sync <= '0;
        else         sd_sync <= (sd_sync << 1) | SYNC_STAGES'(sd_i);
    end

    assign sd_bit      = sd_sync[SYNC_STAGES-1];
    assign sample_edge = (SPI_CPOL == SPI_CPHA) ? sclk_rise : sclk_fall;
    assign shift_edge  = (SPI_CPOL == SPI_CPHA) ? sclk_fall : sclk_rise;

    assign tx_ready_o = ~hold_full;
    assign sd_oe      = (state == ACTIVE);
    assign sd_o       = (state == ACTIVE) & tx_shift[DW-1];

    // A load with an empty holding register sends zeros; a same-cycle accept
    // still lands in the holding register because the load leaves it untouched.
    always_ff @(posedge clk_i or negedge rst_ni) begin
        if (!rst_ni) begin
            state      <= IDLE;
            tx_hold    <= '0;
            hold_full  <= 1'b0;
            tx_shift   <= '0;
            rx_shift   <= '0;
            bit_cnt    <= '0;
            word_end   <= 1'b0;
            word_done  <= 1'b0;
            rx_data_o  <= '0;
            rx_valid_o <= 1'b0;
            overrun_o  <= 1'b0;
            underrun_o <= 1'b0;
        end else begin
            underrun_o <= 1'b0;
            overrun_o  <= 1'b0;
            word_done  <= 1'b0;

            if (tx_valid_i && !hold_full) begin
                tx_hold   <= tx_data_i;
                hold_full <= 1'b1;
            end

            if (rx_valid_o && rx_ready_i) rx_valid_o <= 1'b0;

            if (word_done) begin
                if (rx_valid_o && !rx_ready_i) begin
                    overrun_o <= 1'b1;
                end else begin
                    rx_data_o  <= rx_shift;
                    rx_valid_o <= 1'b1;
                end
            end

            case (state)
                IDLE: begin
                    if (ss_fall) begin
                        state <= ACTIVE;
                        if (hold_full) begin
                            tx_shift  <= tx_hold;
                            hold_full <= 1'b0;
                        end else begin
                            tx_shift   <= '0;
                            underrun_o <= 1'b1;
                        end
                    end
                end
                ACTIVE: begin
                    if (ss_rise) begin
                        state    <= IDLE;
                        bit_cnt  <= '0;
                        word_end <= 1'b0;
                        rx_shift <= '0;
                    end else if (sample_edge) begin
                        rx_shift <= {rx_shift[DW-2:0], sd_bit};
                        if (bit_cnt == LAST_BIT) begin
                            bit_cnt   <= '0;
                            word_done <= 1'b1;
                            word_end  <= 1'b1;
                        end else begin
                            bit_cnt <= bit_cnt + 1'b1;
                        end
                    end else if (shift_edge) begin
                        if (word_end) begin
                            word_end <= 1'b0;
                            if (hold_full) begin
                                tx_shift  <= tx_hold;
                                hold_full <= 1'b0;
                            end else begin
                                tx_shift   <= '0;
                                underrun_o <= 1'b1;
                            end
                        end else begin
                            tx_shift <= tx_shift << 1;
                        end
                    end
                end
                default: state <= IDLE;
            endcase
        end
    end

endmodule

// File: tb/tb_spi_target.sv
// Self-checking bench for spi_target: bit-banged SPI initiator plus a
// word-level reference model of the transmit holding register and rx path.
module tb_spi_target;

    localparam int DW   = 8;
    localparam int SYNC = 2;
    localparam int HALF = 6;

    logic          clk_i      = 1'b0;
    logic          rst_ni     = 1'b0;
    logic          sclk_i     = 1'b0;
    logic          ss_ni      = 1'b1;
    logic          sd_i       = 1'b0;
    logic [DW-1:0] tx_data_i  = '0;
    logic          tx_valid_i = 1'b0;
    logic          rx_ready_i = 1'b0;
    logic          sd_o;
    logic          sd_oe;
    logic          tx_ready_o;
    logic [DW-1:0] rx_data_o;
    logic          rx_valid_o;
    logic          overrun_o;
    logic          underrun_o;

    int vectors     = 0;
    int miscompares = 0;
    int ur_seen     = 0;
    int or_seen     = 0;

    bit            m_pending  = 1'b0;
    logic [DW-1:0] m_hold     = '0;
    bit            m_rx_valid = 1'b0;
    logic [DW-1:0] m_rx_data  = '0;
    int            m_ur       = 0;
    int            m_or       = 0;

    spi_target #(.DW(DW), .SYNC_STAGES(SYNC)) dut (
        .clk_i      (clk_i),
        .rst_ni     (rst_ni),
        .sclk_i     (sclk_i),
        .ss_ni      (ss_ni),
        .sd_i       (sd_i),
        .sd_o       (sd_o),
        .sd_oe      (sd_oe),
        .tx_data_i  (tx_data_i),
        .tx_valid_i (tx_valid_i),
        .tx_ready_o (tx_ready_o),
        .rx_data_o  (rx_data_o),
        .rx_valid_o (rx_valid_o),
        .rx_ready_i (rx_ready_i),
        .overrun_o  (overrun_o),
        .underrun_o (underrun_o)
    );

    always #5 clk_i = ~clk_i;

    // Every cycle an error output is high counts, so a stretched pulse shows up.
    always @(posedge clk_i) begin
        if (underrun_o === 1'b1) ur_seen++;
        if (overrun_o === 1'b1)  or_seen++;
    end

    initial begin
        #500000;
        $display("[TB] FAIL watchdog: simulation did not complete in time");
        $fatal(1, "[TB] watchdog expired");
    end

    // Word-level model: one load at select and one after every complete word.
    task automatic model_frame(input int nbits, input logic [15:0] mosi, input bit inject,
                               input logic [DW-1:0] inj, output logic [15:0] exp_miso);
        int nfull;
        nfull    = nbits / DW;
        exp_miso = '0;
        for (int w = 0; w <= nfull; w++) begin
            logic [DW-1:0] word_out;
            logic [DW-1:0] rx_word;
            if (m_pending) begin
                word_out  = m_hold;
                m_pending = 1'b0;
            end else begin
                word_out = '0;
                m_ur++;
            end
            if (w == 0 && inject) begin
                m_pending = 1'b1;
                m_hold    = inj;
            end
            for (int j = 0; j < DW; j++) begin
                if (w * DW + j < nbits) exp_miso[nbits - 1 - (w * DW + j)] = word_out[DW - 1 - j];
            end
            if (w < nfull) begin
                for (int j = 0; j < DW; j++) rx_word[DW - 1 - j] = mosi[nbits - 1 - (w * DW + j)];
                if (m_rx_valid) m_or++;
                else begin
                    m_rx_valid = 1'b1;
                    m_rx_data  = rx_word;
                end
            end
        end
    endtask

    task automatic spi_bit(input logic mosi, input bit measure, output logic miso, output int lat);
        sd_i = mosi;
        repeat (HALF) @(negedge clk_i);
        miso   = sd_o;
        sclk_i = 1'b1;
        lat    = -1;
        if (measure) begin
            // Cycles are counted from the edge that first samples the raw rise.
            @(posedge clk_i);
            lat = 0;
            for (int k = 0; k < 20; k++) begin
                @(posedge clk_i);
                #1;
                lat++;
                if (rx_valid_o === 1'b1) break;
            end
        end
        repeat (HALF) @(negedge clk_i);
        sclk_i = 1'b0;
    endtask

    task automatic spi_frame(input int nbits, input logic [15:0] mosi, input bit inject,
                             input logic [DW-1:0] inj, input bit meas,
                             output logic [15:0] miso, output int lat);
        logic b;
        int   l;
        miso = '0;
        lat  = -1;
        @(negedge clk_i);
        ss_ni = 1'b0;
        if (inject) begin
            repeat (SYNC + 1) @(posedge clk_i);
            @(negedge clk_i);
            tx_data_i  = inj;
            tx_valid_i = 1'b1;
            @(negedge clk_i);
            tx_valid_i = 1'b0;
        end
        for (int i = 0; i < nbits; i++) begin
            spi_bit(mosi[nbits - 1 - i], meas && (i == DW - 1), b, l);
            miso[nbits - 1 - i] = b;
            if (l >= 0) lat = l;
        end
        repeat (HALF) @(negedge clk_i);
    endtask

    task automatic end_frame();
        @(negedge clk_i);
        ss_ni = 1'b1;
        repeat (12) @(negedge clk_i);
    endtask

    task automatic push_tx(input logic [DW-1:0] d);
        @(negedge clk_i);
        tx_data_i  = d;
        tx_valid_i = 1'b1;
        @(negedge clk_i);
        tx_valid_i = 1'b0;
        if (!m_pending) begin
            m_pending = 1'b1;
            m_hold    = d;
        end
    endtask

    task automatic drain_rx();
        @(negedge clk_i);
        if (m_rx_valid) begin
            rx_ready_i = 1'b1;
            @(negedge clk_i);
            rx_ready_i = 1'b0;
            m_rx_valid = 1'b0;
        end
        @(negedge clk_i);
    endtask

    task automatic test_reset();
        #1;
        vectors++;
        if ({sd_o, sd_oe, tx_ready_o, rx_valid_o, overrun_o, underrun_o} !== 6'b001000) begin
            miscompares++;
            $display("[TB] FAIL reset_flags: got %b expected %b",
                     {sd_o, sd_oe, tx_ready_o, rx_valid_o, overrun_o, underrun_o}, 6'b001000);
        end
        vectors++;
        if (rx_data_o !== '0) begin
            miscompares++;
            $display("[TB] FAIL reset_rx_data: got %h expected %h", rx_data_o, 8'h00);
        end
    endtask

    task automatic test_basic();
        logic [15:0] exp, got;
        int          lat;
        vectors++;
        if (tx_ready_o !== 1'b1) begin
            miscompares++;
            $display("[TB] FAIL basic_ready_before: got %b expected 1", tx_ready_o);
        end
        push_tx(8'hA5);
        vectors++;
        if (tx_ready_o !== 1'b0) begin
            miscompares++;
            $display("[TB] FAIL basic_ready_after: got %b expected 0", tx_ready_o);
        end
        model_frame(8, 16'h003C, 1'b0, '0, exp);
        spi_frame(8, 16'h003C, 1'b0, '0, 1'b1, got, lat);
        vectors++;
        if (sd_oe !== 1'b1) begin
            miscompares++;
            $display("[TB] FAIL basic_oe_active: got %b expected 1", sd_oe);
        end
        end_frame();
        vectors++;
        if (got !== exp) begin
            miscompares++;
            $display("[TB] FAIL basic_miso: got %h expected %h", got, exp);
        end
        vectors++;
        if (lat !== SYNC + 2) begin
            miscompares++;
            $display("[TB] FAIL basic_latency: got %0d expected %0d", lat, SYNC + 2);
        end
        vectors++;
        if ({sd_oe, sd_o} !== 2'b00) begin
            miscompares++;
            $display("[TB] FAIL basic_oe_idle: got %b expected 00", {sd_oe, sd_o});
        end
        vectors++;
        if (rx_valid_o !== m_rx_valid || rx_data_o !== m_rx_data) begin
            miscompares++;
            $display("[TB] FAIL basic_rx: got %b/%h expected %b/%h",
                     rx_valid_o, rx_data_o, m_rx_valid, m_rx_data);
        end
        drain_rx();
        vectors++;
        if (rx_valid_o !== 1'b0) begin
            miscompares++;
            $display("[TB] FAIL basic_rx_drained: got %b expected 0", rx_valid_o);
        end
        vectors++;
        if (ur_seen !== m_ur || or_seen !== m_or) begin
            miscompares++;
            $display("[TB] FAIL basic_errors: got ur=%0d or=%0d expected ur=%0d or=%0d",
                     ur_seen, or_seen, m_ur, m_or);
        end
    endtask

    task automatic test_underrun();
        logic [15:0] exp, got, mosi;
        int          lat;
        mosi = 16'($urandom_range(0, 255));
        model_frame(8, mosi, 1'b0, '0, exp);
        spi_frame(8, mosi, 1'b0, '0, 1'b0, got, lat);
        end_frame();
        vectors++;
        if (got !== exp) begin
            miscompares++;
            $display("[TB] FAIL underrun_miso: got %h expected %h", got, exp);
        end
        vectors++;
        if (ur_seen !== m_ur) begin
            miscompares++;
            $display("[TB] FAIL underrun_count: got %0d expected %0d", ur_seen, m_ur);
        end
        vectors++;
        if (rx_data_o !== m_rx_data) begin
            miscompares++;
            $display("[TB] FAIL underrun_rx: got %h expected %h", rx_data_o, m_rx_data);
        end
        drain_rx();
    endtask

    task automatic test_back_to_back();
        logic [15:0] exp, got;
        int          lat;
        model_frame(16, 16'h1122, 1'b0, '0, exp);
        spi_frame(16, 16'h1122, 1'b0, '0, 1'b0, got, lat);
        end_frame();
        vectors++;
        if (rx_valid_o !== m_rx_valid || rx_data_o !== m_rx_data) begin
            miscompares++;
            $display("[TB] FAIL b2b_rx: got %b/%h expected %b/%h",
                     rx_valid_o, rx_data_o, m_rx_valid, m_rx_data);
        end
        vectors++;
        if (or_seen !== m_or) begin
            miscompares++;
            $display("[TB] FAIL b2b_overrun: got %0d expected %0d", or_seen, m_or);
        end
        vectors++;
        if (got !== exp) begin
            miscompares++;
            $display("[TB] FAIL b2b_miso: got %h expected %h", got, exp);
        end
        drain_rx();
    endtask

    task automatic test_abort();
        logic [15:0]   exp, got, mosi;
        logic [DW-1:0] y;
        int            lat;
        mosi = 16'($urandom_range(0, 31));
        y    = DW'($urandom);
        model_frame(5, mosi, 1'b1, y, exp);
        spi_frame(5, mosi, 1'b1, y, 1'b0, got, lat);
        end_frame();
        vectors++;
        if (rx_valid_o !== 1'b0) begin
            miscompares++;
            $display("[TB] FAIL abort_no_valid: got %b expected 0", rx_valid_o);
        end
        vectors++;
        if (tx_ready_o !== !m_pending) begin
            miscompares++;
            $display("[TB] FAIL abort_hold_kept: got ready=%b expected %b", tx_ready_o, !m_pending);
        end
        model_frame(8, 16'h007E, 1'b0, '0, exp);
        spi_frame(8, 16'h007E, 1'b0, '0, 1'b0, got, lat);
        end_frame();
        vectors++;
        if (got !== exp) begin
            miscompares++;
            $display("[TB] FAIL abort_next_miso: got %h expected %h", got, exp);
        end
        vectors++;
        if (rx_valid_o !== m_rx_valid || rx_data_o !== m_rx_data) begin
            miscompares++;
            $display("[TB] FAIL abort_next_rx: got %b/%h expected %b/%h",
                     rx_valid_o, rx_data_o, m_rx_valid, m_rx_data);
        end
        drain_rx();
    endtask

    task automatic test_reset_mid();
        logic [15:0] exp, got, mosi;
        int          lat;
        push_tx(DW'($urandom));
        mosi = 16'($urandom_range(0, 7));
        model_frame(3, mosi, 1'b0, '0, exp);
        spi_frame(3, mosi, 1'b0, '0, 1'b0, got, lat);
        rst_ni = 1'b0;
        m_pending  = 1'b0;
        m_rx_valid = 1'b0;
        m_rx_data  = '0;
        #1;
        vectors++;
        if ({sd_o, sd_oe, tx_ready_o, rx_valid_o, overrun_o, underrun_o} !== 6'b001000
            || rx_data_o !== '0) begin
            miscompares++;
            $display("[TB] FAIL midreset_outputs: got %b/%h expected %b/%h",
                     {sd_o, sd_oe, tx_ready_o, rx_valid_o, overrun_o, underrun_o}, rx_data_o,
                     6'b001000, 8'h00);
        end
        repeat (3) @(negedge clk_i);
        rst_ni = 1'b1;
        repeat (10) @(negedge clk_i);
        vectors++;
        if (sd_oe !== 1'b0) begin
            miscompares++;
            $display("[TB] FAIL midreset_stays_idle: got %b expected 0", sd_oe);
        end
        end_frame();
        model_frame(8, 16'h0081, 1'b0, '0, exp);
        spi_frame(8, 16'h0081, 1'b0, '0, 1'b0, got, lat);
        end_frame();
        vectors++;
        if (rx_valid_o !== m_rx_valid || rx_data_o !== m_rx_data) begin
            miscompares++;
            $display("[TB] FAIL midreset_next_rx: got %b/%h expected %b/%h",
                     rx_valid_o, rx_data_o, m_rx_valid, m_rx_data);
        end
        vectors++;
        if (got !== exp) begin
            miscompares++;
            $display("[TB] FAIL midreset_next_miso: got %h expected %h", got, exp);
        end
        drain_rx();
    endtask

    task automatic test_tx_coincide();
        logic [15:0]   exp, got, mosi;
        logic [DW-1:0] d;
        int            lat;
        mosi = 16'($urandom);
        d    = DW'($urandom_range(1, 255));
        model_frame(16, mosi, 1'b1, d, exp);
        spi_frame(16, mosi, 1'b1, d, 1'b0, got, lat);
        end_frame();
        vectors++;
        if (got !== exp) begin
            miscompares++;
            $display("[TB] FAIL coincide_miso: got %h expected %h", got, exp);
        end
        vectors++;
        if (ur_seen !== m_ur) begin
            miscompares++;
            $display("[TB] FAIL coincide_underrun: got %0d expected %0d", ur_seen, m_ur);
        end
        drain_rx();
    endtask

    task automatic test_random();
        for (int it = 0; it < 8; it++) begin
            logic [15:0] exp, got, mosi;
            int          nb, lat;
            nb   = ($urandom_range(0, 1) == 1) ? 16 : 8;
            mosi = (nb == 16) ? 16'($urandom) : 16'($urandom_range(0, 255));
            if ($urandom_range(0, 1) == 1) begin
                vectors++;
                if (tx_ready_o !== !m_pending) begin
                    miscompares++;
                    $display("[TB] FAIL rand_ready[%0d]: got %b expected %b", it, tx_ready_o, !m_pending);
                end
                push_tx(DW'($urandom));
            end
            if ($urandom_range(0, 1) == 1) drain_rx();
            model_frame(nb, mosi, 1'b0, '0, exp);
            spi_frame(nb, mosi, 1'b0, '0, 1'b0, got, lat);
            end_frame();
            vectors++;
            if (got !== exp) begin
                miscompares++;
                $display("[TB] FAIL rand_miso[%0d]: got %h expected %h", it, got, exp);
            end
            vectors++;
            if (rx_valid_o !== m_rx_valid || rx_data_o !== m_rx_data) begin
                miscompares++;
                $display("[TB] FAIL rand_rx[%0d]: got %b/%h expected %b/%h",
                         it, rx_valid_o, rx_data_o, m_rx_valid, m_rx_data);
            end
            vectors++;
            if (ur_seen !== m_ur || or_seen !== m_or) begin
                miscompares++;
                $display("[TB] FAIL rand_errors[%0d]: got ur=%0d or=%0d expected ur=%0d or=%0d",
                         it, ur_seen, or_seen, m_ur, m_or);
            end
        end
    endtask

    initial begin
        repeat (3) @(negedge clk_i);
        test_reset();
        rst_ni = 1'b1;
        repeat (4) @(negedge clk_i);
        test_basic();
        test_underrun();
        test_back_to_back();
        test_abort();
        test_reset_mid();
        test_tx_coincide();
        test_random();
        $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
        $finish;
    end

endmodule
